pipeline_stall_sequencer: RTL and testbench

//  Central stall/flush sequencer for the 64-bit RISC-V pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_stall_sequencer_if.sv | 33 +++
 rtl/pipeline_stall_sequencer.sv | 150 +++++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_sequencer_if.sv
// Handshake bundle between the hazard/memory/MDU sources and the stall/flush sequencer.
// master = pipeline side (raises requests, consumes controls); slave = sequencer.
interface pipeline_stall_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use;
  logic             redirect_ex;
  logic             mdu_start;
  logic             mdu_done;
  logic             dmem_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mdu_timeout;
  logic [CNT_W-1:0] perf_stall_cyc;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output load_use, redirect_ex, mdu_start, mdu_done, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mdu_timeout, perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  load_use, redirect_ex, mdu_start, mdu_done, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mdu_timeout, perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: fixed-priority FSM, combinational controls.
// Define PIPE_PERF_CNT_EN to build the stall-cycle and applied-redirect counters.
module pipeline_stall_sequencer #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_stall_sequencer_if.slave   bus
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MDU_WAIT = 2'd2;
  localparam logic [1:0] S_MEM_WAIT = 2'd3;

  localparam int unsigned         CW     = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0]       TO_VAL = CW'(MDU_TIMEOUT);
  localparam logic [CW-1:0]       CNT_1  = CW'(1);

  logic [1:0]    state_q,   state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;

  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mdu_timeout_c;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    pending_d     = pending_q;
    mdu_cnt_d     = mdu_cnt_q;
    pc_en_c       = 1'b1;
    if_id_en_c    = 1'b1;
    id_ex_en_c    = 1'b1;
    ex_mem_en_c   = 1'b1;
    mem_wb_en_c   = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    mdu_timeout_c = 1'b0;

    case (state_q)
      S_RUN, S_LU_STALL: begin
        state_d = S_RUN;
        if (bus.dmem_busy) begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
          pending_d = bus.redirect_ex;
          state_d   = S_MEM_WAIT;
        end else if (bus.redirect_ex) begin
          // Younger instructions are squashed, so their load_use/mdu_start are moot.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (bus.mdu_start) begin
          {pc_en_c, if_id_en_c, id_ex_en_c} = '0;
          mdu_cnt_d = CNT_1;
          state_d   = S_MDU_WAIT;
        end else if (bus.load_use && (state_q == S_RUN)) begin
          pc_en_c       = 1'b0;
          if_id_en_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          state_d       = S_LU_STALL;
        end
      end

      S_MDU_WAIT: begin
        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c} = '0;
        // Saturate so a long memory freeze cannot wrap past the timeout.
        mdu_cnt_d = (mdu_cnt_q == TO_VAL) ? mdu_cnt_q : mdu_cnt_q + CNT_1;
        if (bus.dmem_busy) begin
          mem_wb_en_c = 1'b0;
        end else if (bus.mdu_done) begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c} = '1;
          mdu_cnt_d = '0;
          state_d   = S_RUN;
        end else if (mdu_cnt_q == TO_VAL) begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c} = '1;
          mdu_timeout_c = 1'b1;
          mdu_cnt_d     = '0;
          state_d       = S_RUN;
        end
      end

      S_MEM_WAIT: begin
        if (bus.dmem_busy) begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
          pending_d = pending_q | bus.redirect_ex;
        end else begin
          // The held EX instruction may re-assert its redirect on release; treat both as one.
          if_id_flush_c = pending_q | bus.redirect_ex;
          id_ex_flush_c = pending_q | bus.redirect_ex;
          pending_d     = 1'b0;
          state_d       = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pending_q <= 1'b0;
      mdu_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Reset gates the controls directly so the pipe freezes the instant rst_n falls.
  assign bus.pc_en       = rst_n & pc_en_c;
  assign bus.if_id_en    = rst_n & if_id_en_c;
  assign bus.id_ex_en    = rst_n & id_ex_en_c;
  assign bus.ex_mem_en   = rst_n & ex_mem_en_c;
  assign bus.mem_wb_en   = rst_n & mem_wb_en_c;
  assign bus.if_id_flush = rst_n & if_id_flush_c;
  assign bus.id_ex_flush = rst_n & id_ex_flush_c;
  assign bus.mdu_timeout = rst_n & mdu_timeout_c;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  // An IF/ID flush happens exactly when a redirect is applied.
  always_comb begin
    perf_stall_d = pc_en_c       ? perf_stall_q : perf_stall_q + CNT_W'(1);
    perf_flush_d = if_id_flush_c ? perf_flush_q + CNT_W'(1) : perf_flush_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall_cyc = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: event-level model compared every cycle,
// plus literal control-vector expectations at the interesting cycles.
module tb_pipeline_stall_sequencer;
  localparam int unsigned TO    = 6;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  pipeline_stall_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_sequencer #(.MDU_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mdu_timeout}
  function automatic logic [7:0] act_ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mdu_timeout};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the pipe is either running, frozen on memory, or waiting on a multi-cycle op.
  bit frozen, mdu_busy, bubble, pend;
  int age, stall_cnt, flush_cnt;

  task automatic eval(output logic [7:0] c, output bit n_frozen, output bit n_mdu,
                      output bit n_bubble, output bit n_pend, output int n_age);
    bit pc, ifid, idex, exmem, memwb, f1, f2, tmo;
    {pc, ifid, idex, exmem, memwb} = 5'b11111;
    {f1, f2, tmo} = 3'b000;
    n_frozen = frozen; n_mdu = mdu_busy; n_bubble = 1'b0; n_pend = pend; n_age = age;
    if (frozen) begin
      if (bus.dmem_busy) begin
        {pc, ifid, idex, exmem, memwb} = 5'b0;
        n_pend = pend | bus.redirect_ex;
      end else begin
        f1 = pend | bus.redirect_ex; f2 = f1;
        n_frozen = 1'b0; n_pend = 1'b0;
      end
    end else if (mdu_busy) begin
      n_age = (age < TO) ? age + 1 : TO;
      if (bus.dmem_busy) {pc, ifid, idex, exmem, memwb} = 5'b0;
      else if (bus.mdu_done) n_mdu = 1'b0;
      else if (age == TO) begin tmo = 1'b1; n_mdu = 1'b0; end
      else {pc, ifid, idex, exmem} = 4'b0;
    end else begin
      if (bus.dmem_busy) begin
        {pc, ifid, idex, exmem, memwb} = 5'b0;
        n_frozen = 1'b1; n_pend = bus.redirect_ex;
      end else if (bus.redirect_ex) begin
        f1 = 1'b1; f2 = 1'b1;
      end else if (bus.mdu_start) begin
        {pc, ifid, idex} = 3'b0;
        n_mdu = 1'b1; n_age = 1;
      end else if (bus.load_use && !bubble) begin
        pc = 1'b0; ifid = 1'b0; f2 = 1'b1; n_bubble = 1'b1;
      end
    end
    c = rst_n ? {pc, ifid, idex, exmem, memwb, f1, f2, tmo} : 8'h00;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] c;
    bit nf, nm, nb, np;
    int na;
    if (!rst_n) begin
      frozen = 0; mdu_busy = 0; bubble = 0; pend = 0; age = 0; stall_cnt = 0; flush_cnt = 0;
    end else begin
      eval(c, nf, nm, nb, np, na);
      if (!c[7]) stall_cnt++;
      if (c[2])  flush_cnt++;
      frozen = nf; mdu_busy = nm; bubble = nb; pend = np; age = na;
    end
  end

  always @(negedge clk) begin
    logic [7:0] c;
    bit nf, nm, nb, np;
    int na;
    eval(c, nf, nm, nb, np, na);
    check("cycle_ctl", {56'd0, act_ctl()}, {56'd0, c});
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall", {32'd0, bus.perf_stall_cyc}, 64'(stall_cnt));
    check("perf_flush", {32'd0, bus.perf_flush_cnt}, 64'(flush_cnt));
`else
    check("perf_stall", {32'd0, bus.perf_stall_cyc}, 64'd0);
    check("perf_flush", {32'd0, bus.perf_flush_cnt}, 64'd0);
`endif
  end

  task automatic step(input bit lu, input bit rd, input bit ms, input bit md, input bit mb);
    @(posedge clk);
    #1;
    bus.load_use = lu; bus.redirect_ex = rd; bus.mdu_start = ms;
    bus.mdu_done = md; bus.dmem_busy = mb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.load_use = 0; bus.redirect_ex = 0; bus.mdu_start = 0; bus.mdu_done = 0; bus.dmem_busy = 0;
    #3 check("reset_ctl", {56'd0, act_ctl()}, 64'h00);
    #19 rst_n = 1'b1;

    // Load-use bubble, then the one-cycle LU_STALL ignores a repeated load_use.
    step(1, 0, 0, 0, 0); check("lu_first",  {56'd0, act_ctl()}, 64'b00111010);
    step(1, 0, 0, 0, 0); check("lu_stall",  {56'd0, act_ctl()}, 64'b11111000);
    step(0, 0, 0, 0, 0); check("lu_back",   {56'd0, act_ctl()}, 64'b11111000);

    // Done arriving on the same cycle the counter hits the limit: done wins, no pulse.
    step(0, 0, 1, 0, 0); check("mdu_start", {56'd0, act_ctl()}, 64'b00011000);
    idle(5);             check("mdu_wait",  {56'd0, act_ctl()}, 64'b00001000);
    step(0, 0, 0, 1, 0); check("mdu_done",  {56'd0, act_ctl()}, 64'b11111000);
    idle(1);

    // No done: pulse on the TO-th waiting cycle.
    step(0, 0, 1, 0, 0);
    idle(TO - 1);        check("mdu_pre_to", {56'd0, act_ctl()}, 64'b00001000);
    idle(1);             check("mdu_to",     {56'd0, act_ctl()}, 64'b11111001);
    idle(1);             check("mdu_to_run", {56'd0, act_ctl()}, 64'b11111000);

    // Memory freeze inside an MDU wait stalls the drain stage too.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1); check("mdu_mem",   {56'd0, act_ctl()}, 64'b00000000);
    step(0, 1, 0, 1, 0); check("mdu_done2", {56'd0, act_ctl()}, 64'b11111000);

    // Redirect latched across a memory freeze and applied on release.
    step(0, 1, 0, 0, 1); check("mem_frz1",  {56'd0, act_ctl()}, 64'b00000000);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1); check("mem_frz3",  {56'd0, act_ctl()}, 64'b00000000);
    step(0, 0, 0, 0, 0); check("mem_rel",   {56'd0, act_ctl()}, 64'b11111110);
    idle(1);             check("mem_after", {56'd0, act_ctl()}, 64'b11111000);
`ifdef PIPE_PERF_CNT_EN
    check("perf_flush_lit", {32'd0, bus.perf_flush_cnt}, 64'd1);
`endif

    // Redirect outranks load_use and mdu_start in the same cycle.
    step(1, 1, 1, 0, 0); check("rd_combo",  {56'd0, act_ctl()}, 64'b11111110);
    idle(1);             check("rd_after",  {56'd0, act_ctl()}, 64'b11111000);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0); check("lu_then_rd", {56'd0, act_ctl()}, 64'b11111110);

    // Asynchronous reset in the middle of an MDU wait.
    step(0, 0, 1, 0, 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {56'd0, act_ctl()}, 64'b00000000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1);             check("post_rst",  {56'd0, act_ctl()}, 64'b11111000);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
